// File: rtl/mram_access_arbiter.sv
// Two-port round-robin arbiter that owns the MRAM pins and runs one timed
// setup/access/hold strobe sequence per granted request.
module mram_access_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int SETUP_CYC  = 1,
   parameter int ACCESS_CYC = 4,
   parameter int HOLD_CYC   = 1
) (
   input  logic              FPGA_clk,
   input  logic              FPGA_rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [1:0]        be0,
   input  logic [1:0]        be1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mram_addr,
   output logic [DATA_W-1:0] mram_dq_out,
   output logic              mram_dq_oe,
   input  logic [DATA_W-1:0] mram_dq_in,
   output logic              chip_en_n,
   output logic              read_en_n,
   output logic              write_en_n,
   output logic              lb_en_n,
   output logic              ub_en_n
);

   localparam int SETUP_EFF  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
   localparam int ACCESS_EFF = (ACCESS_CYC < 1) ? 1 : ACCESS_CYC;
   localparam int HOLD_EFF   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
   localparam logic [7:0] SETUP_LAST  = 8'(SETUP_EFF - 1);
   localparam logic [7:0] ACCESS_LAST = 8'(ACCESS_EFF - 1);
   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_EFF - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t            state_reg, state_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic              owner_reg, owner_next;
   logic              last_served_reg, last_served_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [1:0]        be_reg, be_next;
   logic [DATA_W-1:0] rdata_reg, rdata_next;
   logic [1:0]        gnt_reg, gnt_next;
   logic [1:0]        done_reg, done_next;
   logic              winner;

   always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
      if (FPGA_rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         owner_reg       <= 1'b0;
         last_served_reg <= 1'b1;
         we_reg          <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         be_reg          <= '0;
         rdata_reg       <= '0;
         gnt_reg         <= '0;
         done_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         owner_reg       <= owner_next;
         last_served_reg <= last_served_next;
         we_reg          <= we_next;
         addr_reg        <= addr_next;
         wdata_reg       <= wdata_next;
         be_reg          <= be_next;
         rdata_reg       <= rdata_next;
         gnt_reg         <= gnt_next;
         done_reg        <= done_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      owner_next       = owner_reg;
      last_served_next = last_served_reg;
      we_next          = we_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      be_next          = be_reg;
      rdata_next       = rdata_reg;
      gnt_next         = 2'b00;
      done_next        = 2'b00;
      // On a tie the port that was not served last wins.
      winner           = (req0 && req1) ? ~last_served_reg : req1;

      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               state_next        = SETUP;
               cnt_next          = '0;
               owner_next        = winner;
               last_served_next  = winner;
               we_next           = winner ? we1    : we0;
               addr_next         = winner ? addr1  : addr0;
               wdata_next        = winner ? wdata1 : wdata0;
               be_next           = winner ? be1    : be0;
               gnt_next[winner]  = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_reg == SETUP_LAST) begin
               state_next = ACCESS;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ACCESS: begin
            if (cnt_reg == ACCESS_LAST) begin
               state_next = HOLD;
               cnt_next   = '0;
               if (!we_reg) begin
                  rdata_next = mram_dq_in;
               end
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         HOLD: begin
            if (cnt_reg == HOLD_LAST) begin
               state_next           = IDLE;
               cnt_next             = '0;
               done_next[owner_reg] = 1'b1;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Strobes decode straight from state so an asynchronous reset releases them at once.
   assign busy        = (state_reg != IDLE);
   assign chip_en_n   = ~busy;
   assign read_en_n   = ~((state_reg == ACCESS) && !we_reg);
   assign write_en_n  = ~((state_reg == ACCESS) && we_reg);
   assign lb_en_n     = ~(busy && be_reg[0]);
   assign ub_en_n     = ~(busy && be_reg[1]);
   assign mram_dq_oe  = busy && we_reg;
   assign mram_addr   = addr_reg;
   assign mram_dq_out = wdata_reg;
   assign rdata       = rdata_reg;
   assign gnt0        = gnt_reg[0];
   assign gnt1        = gnt_reg[1];
   assign done0       = done_reg[0];
   assign done1       = done_reg[1];

endmodule

// File: tb/tb_mram_access_arbiter.sv
// Bench for mram_access_arbiter: directed table, alternation, reset abort,
// short-timing instance and randomized traffic against a memory/arbiter model.
module tb_mram_access_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int S_C = 1;
   localparam int A_C = 4;
   localparam int H_C = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_init = 1'b1;
   logic [1:0]    req = 2'b00;
   logic [1:0]    we = 2'b00;
   logic [AW-1:0] addr_p [2];
   logic [DW-1:0] wdata_p [2];
   logic [1:0]    be_p [2];

   logic          gnt0, gnt1, done0, done1, busy, mram_dq_oe;
   logic          chip_en_n, read_en_n, write_en_n, lb_en_n, ub_en_n;
   logic [DW-1:0] rdata, mram_dq_out, mram_dq_in;
   logic [AW-1:0] mram_addr;
   logic [1:0]    gnt_v, done_v;

   // second instance with short, clamped timing
   logic          s6_req = 1'b0;
   logic          s6_gnt0, s6_gnt1, s6_done0, s6_done1, s6_busy, s6_oe;
   logic          s6_ce, s6_re, s6_we, s6_lb, s6_ub;
   logic [DW-1:0] s6_rdata, s6_dq_out;
   logic [AW-1:0] s6_addr;

   always #5 clk = ~clk;

   mram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S_C), .ACCESS_CYC(A_C), .HOLD_CYC(H_C)) u_dut (
      .FPGA_clk(clk), .FPGA_rst(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr_p[0]), .addr1(addr_p[1]), .wdata0(wdata_p[0]), .wdata1(wdata_p[1]),
      .be0(be_p[0]), .be1(be_p[1]),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .busy(busy), .mram_addr(mram_addr), .mram_dq_out(mram_dq_out),
      .mram_dq_oe(mram_dq_oe), .mram_dq_in(mram_dq_in),
      .chip_en_n(chip_en_n), .read_en_n(read_en_n), .write_en_n(write_en_n),
      .lb_en_n(lb_en_n), .ub_en_n(ub_en_n)
   );

   mram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(3), .ACCESS_CYC(0), .HOLD_CYC(0)) u_dut6 (
      .FPGA_clk(clk), .FPGA_rst(rst),
      .req0(s6_req), .req1(1'b0), .we0(1'b1), .we1(1'b0),
      .addr0(20'h00ABC), .addr1(20'h0), .wdata0(16'h0F0F), .wdata1(16'h0),
      .be0(2'b11), .be1(2'b00),
      .gnt0(s6_gnt0), .gnt1(s6_gnt1), .done0(s6_done0), .done1(s6_done1),
      .rdata(s6_rdata), .busy(s6_busy), .mram_addr(s6_addr), .mram_dq_out(s6_dq_out),
      .mram_dq_oe(s6_oe), .mram_dq_in(16'h0),
      .chip_en_n(s6_ce), .read_en_n(s6_re), .write_en_n(s6_we),
      .lb_en_n(s6_lb), .ub_en_n(s6_ub)
   );

   assign gnt_v  = {gnt1, gnt0};
   assign done_v = {done1, done0};

   function automatic logic [DW-1:0] init_val(input int i);
      logic [7:0] b;
      b = 8'(i);
      return 16'hA5A5 ^ {b, b};
   endfunction

   // MRAM device: 16 words decoded from the low address bits
   logic [DW-1:0] mram_mem [16];
   always_comb mram_dq_in = (!chip_en_n && !read_en_n) ? mram_mem[mram_addr[3:0]] : 16'hDEAD;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mram_mem[i] <= init_val(i);
      end else if (!chip_en_n && !write_en_n && mram_dq_oe) begin
         if (!lb_en_n) mram_mem[mram_addr[3:0]][7:0]  <= mram_dq_out[7:0];
         if (!ub_en_n) mram_mem[mram_addr[3:0]][15:8] <= mram_dq_out[15:8];
      end
   end

   // reference model state
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] ref_rdata = '0;
   int            ref_last = 1;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
      if (b[0]) ref_mem[a[3:0]][7:0]  = d[7:0];
      if (b[1]) ref_mem[a[3:0]][15:8] = d[15:8];
   endtask

   // Requester p already has req high; follow its access from grant to done.
   task automatic serve(input int p, input logic [DW-1:0] exp_rd);
      int            n;
      int            len;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]    b;
      logic [1:0]    pbit;
      logic          in_acc;
      w = we[p]; a = addr_p[p]; d = wdata_p[p]; b = be_p[p];
      pbit = (p == 0) ? 2'b01 : 2'b10;
      len = S_C + A_C + H_C;
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt_v[p] !== 1'b1 && n < 40);
      if (gnt_v[p] !== 1'b1) begin
         chk("gnt_timeout", 64'(gnt_v), 64'(pbit));
         req[p] = 1'b0;
         return;
      end
      req[p] = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k > 0) tick();
         in_acc = (k >= S_C) && (k < S_C + A_C);
         chk("phase_strobes",
             64'({chip_en_n, read_en_n, write_en_n, lb_en_n, ub_en_n, mram_dq_oe, busy, gnt_v, done_v}),
             64'({1'b0, !(in_acc && !w), !(in_acc && w), ~b[0], ~b[1], w, 1'b1,
                  (k == 0) ? pbit : 2'b00, 2'b00}));
         chk("phase_bus", 64'({mram_addr, w ? mram_dq_out : 16'h0}), 64'({a, w ? d : 16'h0}));
      end
      tick();
      chk("done_cycle",
          64'({done_v, gnt_v, chip_en_n, read_en_n, write_en_n, lb_en_n, ub_en_n, mram_dq_oe, busy}),
          64'({pbit, 2'b00, 5'b11111, 1'b0, 1'b0}));
      chk("rdata", 64'(rdata), 64'(exp_rd));
      $display("txn port=%0d we=%0d addr=%05h wdata=%04h be=%02b rdata=%04h exp=%04h",
               p, w, a, d, b, rdata, exp_rd);
      ref_last = p;
      if (w) ref_write(a, d, b);
      else   ref_rdata = ref_mem[a[3:0]];
   endtask

   task automatic launch(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] b);
      we[p] = w; addr_p[p] = a; wdata_p[p] = d; be_p[p] = b; req[p] = 1'b1;
   endtask

   typedef struct {
      int            port;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]    b;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, ng, pend, win;
      bit seen_low;
      for (int i = 0; i < 2; i++) begin
         addr_p[i] = '0; wdata_p[i] = '0; be_p[i] = '0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      tbl[0] = '{0, 1'b1, 20'h12345, 16'hBEEF, 2'b11, 16'h0000};
      tbl[1] = '{1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hA5A5};
      tbl[2] = '{0, 1'b1, 20'h00003, 16'h1234, 2'b01, 16'hA5A5};
      tbl[3] = '{1, 1'b0, 20'h00003, 16'h0000, 2'b11, 16'hA634};
      tbl[4] = '{0, 1'b1, 20'h00007, 16'hFFFF, 2'b00, 16'hA634};
      tbl[5] = '{0, 1'b0, 20'h00007, 16'h0000, 2'b11, 16'hA2A2};
      tbl[6] = '{1, 1'b0, 20'h12345, 16'h0000, 2'b11, 16'hBEEF};
      tbl[7] = '{1, 1'b1, 20'h00008, 16'hC3C3, 2'b10, 16'hBEEF};
      tbl[8] = '{0, 1'b0, 20'h00008, 16'h0000, 2'b11, 16'hC3AD};

      // reset state
      #1;
      chk("reset_strobes",
          64'({chip_en_n, read_en_n, write_en_n, lb_en_n, ub_en_n, mram_dq_oe, busy, gnt_v, done_v}),
          64'(11'b11111_0_0_00_00));
      chk("reset_buses", 64'({mram_addr, mram_dq_out, rdata}), 64'h0);
      repeat (3) tick();
      rst = 1'b0;
      mem_init = 1'b0;
      tick();

      // directed table
      foreach (tbl[i]) begin
         launch(tbl[i].port, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
         serve(tbl[i].port, tbl[i].exp_rd);
      end

      // both requests held high: grants alternate starting with the other port
      launch(0, 1'b0, 20'h00001, 16'h0, 2'b11);
      launch(1, 1'b0, 20'h00002, 16'h0, 2'b11);
      gap = 0; ng = 0; seen_low = 0;
      win = (ref_last == 0) ? 1 : 0;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         tick();
         if (gnt_v != 2'b00) begin
            chk("alt_grant", 64'(gnt_v), 64'((win == 0) ? 2'b01 : 2'b10));
            win = 1 - win;
            ng++;
         end
         if (chip_en_n) begin
            if (seen_low) gap++;
         end else begin
            if (gap > 0) chk("alt_idle_gap", 64'(gap), 64'd1);
            gap = 0;
            seen_low = 1;
         end
      end
      chk("alt_grant_count", 64'(ng), 64'd4);
      req = 2'b00;
      repeat (10) tick();
      ref_last = 1 - win;
      ref_rdata = ref_mem[(ref_last == 0) ? 1 : 2];
      chk("alt_rdata", 64'(rdata), 64'(ref_rdata));

      // randomized traffic
      for (int r = 0; r < 30; r++) begin
         pend = $urandom_range(1, 3);
         for (int p = 0; p < 2; p++) begin
            if (pend[p]) launch(p, 1'($urandom), 20'($urandom), 16'($urandom), 2'($urandom));
         end
         while (pend != 0) begin
            if (pend == 3) win = (ref_last == 0) ? 1 : 0;
            else           win = (pend == 2) ? 1 : 0;
            serve(win, we[win] ? ref_rdata : ref_mem[addr_p[win][3:0]]);
            pend = pend & ~(1 << win);
         end
      end

      // reset in the middle of ACCESS
      launch(0, 1'b1, 20'h00009, 16'h5555, 2'b11);
      begin
         int n = 0;
         do begin
            tick();
            n++;
         end while (gnt0 !== 1'b1 && n < 40);
         chk("rst_gnt", 64'(gnt0), 64'd1);
      end
      req[0] = 1'b0;
      tick();
      tick();
      ref_write(20'h00009, 16'h5555, 2'b11);
      rst = 1'b1;
      #1;
      chk("rst_async_release",
          64'({chip_en_n, read_en_n, write_en_n, lb_en_n, ub_en_n, mram_dq_oe, busy}),
          64'(7'b11111_0_0));
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_no_done", 64'({done_v, gnt_v}), 64'h0);
      end
      rst = 1'b0;
      ref_last = 1;
      ref_rdata = '0;
      chk("rst_rdata", 64'(rdata), 64'h0);
      tick();
      launch(0, 1'b0, 20'h00009, 16'h0, 2'b11);
      serve(0, 16'h5555);

      // short-timing instance: 3 setup cycles, strobe low exactly one cycle
      s6_req = 1'b1;
      begin
         int n = 0;
         do begin
            tick();
            n++;
         end while (s6_gnt0 !== 1'b1 && n < 40);
         chk("s6_gnt", 64'(s6_gnt0), 64'd1);
      end
      s6_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         chk("s6_phase", 64'({s6_ce, s6_we, s6_re, s6_oe, s6_done0}),
             64'({1'b0, (k == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0}));
      end
      tick();
      chk("s6_done", 64'({s6_done0, s6_ce, s6_we}), 64'(3'b111));
      $display("txn s6 port=0 we=1 addr=%05h done=%0d", s6_addr, s6_done0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
